ram_stream_reader: RTL and testbench

Read-side master for the team's single-port RAM: on a start command it walks a contiguous, wrap-around address range, issues one-cycle-latency RAM reads and presents the words on a valid/ready stream with full backpressure support. It sits between a `single_port_ram` instance and a streaming consumer such as a serializer, DMA-out path or checksum engine. Flow control prevents read data from ever being lost, and the stream sustains one word per cycle when the sink never stalls.

---
 rtl/ram_stream_reader.sv | 135 +++++++++++++
 tb/tb_ram_stream_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Walks a wrap-around RAM address range and streams the read words out on a
// valid/ready interface, reading at most two words ahead of the sink.
module ram_stream_reader #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic             ram_ena,
  output logic             ram_wea,
  output logic [AW-1:0]    ram_addr,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [AW:0]   ONE      = (AW + 1)'(1);
  localparam logic [AW-1:0] ADDR_TOP = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW:0]      len_q, len_d;
  logic [AW:0]      issued_q, issued_d;
  logic [AW:0]      delivered_q, delivered_d;
  logic             out_q, out_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];

  logic       pop;
  logic [2:0] occ;

  assign m_valid  = (cnt_q != 2'd0);
  assign m_data   = mem_q[rd_ptr_q];
  assign m_last   = m_valid && (delivered_q == len_q - ONE);
  assign pop      = m_valid && m_ready;
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign ram_wea  = 1'b0;
  assign ram_addr = addr_q;

  // Occupancy counts the word already in flight so the FIFO can never overflow.
  assign occ     = {1'b0, cnt_q} + {2'b00, out_q};
  assign ram_ena = (state_q == S_RUN) && (issued_q < len_q) &&
                   (occ < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    out_d       = ram_ena;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_d       = mem_q;

    if (out_q) begin
      mem_d[wr_ptr_q] = ram_dout;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d    = ~rd_ptr_q;
      delivered_d = delivered_q + ONE;
    end
    cnt_d = cnt_q + {1'b0, out_q} - {1'b0, pop};

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          addr_d      = base_addr;
          len_d       = len;
          issued_d    = '0;
          delivered_d = '0;
          state_d     = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (ram_ena) begin
          issued_d = issued_q + ONE;
          addr_d   = (addr_q == ADDR_TOP) ? '0 : addr_q + AW'(1);
          if (issued_q + ONE == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && (delivered_q + ONE == len_q)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      out_q       <= 1'b0;
      cnt_q       <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_q       <= mem_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(out_q && !pop && (cnt_q == 2'd2)));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized scoreboard bench for ram_stream_reader: DEPTH=8 main instance plus
// a DEPTH=6 instance for non-power-of-two wrap.
module tb_ram_stream_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      len;
  logic             busy, done, ram_ena, ram_wea, m_valid, m_ready, m_last;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_dout, m_data;

  logic             start6;
  logic [2:0]       base6;
  logic [3:0]       len6;
  logic             busy6, done6, ena6, wea6, valid6, ready6, last6;
  logic [2:0]       addr6;
  logic [WIDTH-1:0] dout6, data6;

  always #5 clk = ~clk;

  ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(6)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .base_addr(base6), .len(len6),
    .busy(busy6), .done(done6), .ram_ena(ena6), .ram_wea(wea6),
    .ram_addr(addr6), .ram_dout(dout6), .m_data(data6),
    .m_valid(valid6), .m_ready(ready6), .m_last(last6)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] mem6 [6];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h10 + i);
    for (int i = 0; i < 6; i++) mem6[i] = 8'(8'h10 + i);
    ram_dout = '0;
    dout6    = '0;
  end

  // One-cycle-latency RAM models; data is only updated on an enabled read.
  always @(posedge clk) begin
    if (ram_ena) ram_dout <= mem[ram_addr];
    if (ena6)    dout6    <= mem6[addr6];
  end

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int mon_base = 0;
  int mon_len  = 0;
  int tb_issued = 0;
  int tb_popped = 0;
  bit exp_zl   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop/compare, done timing, address sequence, stall stability.
  bit               last_hs_prev = 0;
  bit               stall_prev   = 0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;
  always @(negedge clk) begin
    if (rst) begin
      last_hs_prev = 0;
      stall_prev   = 0;
      tb_issued    = 0;
      tb_popped    = 0;
    end else begin
      bit   hs;
      exp_t e;
      hs = m_valid && m_ready;
      chk("done_timing", done, last_hs_prev || exp_zl);
      chk("wea_zero", ram_wea, 0);
      if (ram_ena) begin
        chk("ram_addr", ram_addr, (mon_base + tb_issued) % DEPTH);
        tb_issued++;
        chk("issue_within_len", tb_issued <= mon_len, 1);
      end
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      last_hs_prev = 0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.data);
          chk("m_last", m_last, e.last);
          last_hs_prev = e.last;
        end
        tb_popped++;
      end
      chk("readahead", (tb_issued - tb_popped) <= 2, 1);
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic do_start(input int b, input int ln);
    exp_t e;
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW + 1)'(ln);
    mon_base  = b;
    mon_len   = ln;
    tb_issued = 0;
    tb_popped = 0;
    for (int i = 0; i < ln; i++) begin
      e.data = mem[(b + i) % DEPTH];
      e.last = (i == ln - 1);
      exp_q.push_back(e);
    end
  endtask

  // rmode 0: sink always ready; 1: random with a 10-cycle stall.
  task automatic xfer(input int b, input int ln, input int rmode, input bit poke);
    bit seen = 0;
    do_start(b, ln);
    for (int cyc = 1; cyc < 400 && !seen; cyc++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      exp_zl = (cyc == 1) && (ln == 0);
      if (rmode == 0) m_ready = 1'b1;
      else m_ready = (cyc >= 5 && cyc < 15) ? 1'b0 : 1'($urandom_range(0, 1));
      if (poke && cyc == 4) begin
        start     = 1'b1;
        base_addr = AW'(b + 3);
        len       = (AW + 1)'(2);
      end
      @(negedge clk);
      if (cyc == 1) begin
        chk("busy_c1", busy, ln != 0);
        chk("ena_c1", ram_ena, ln != 0);
        if (ln != 0) chk("addr_c1", ram_addr, b);
        if (ln == 0) chk("zero_len_done", done, 1);
      end
      if (cyc == 2) chk("valid_c2", m_valid, 0);
      if (cyc == 3 && ln != 0) chk("valid_c3", m_valid, 1);
      if (rmode == 0 && cyc >= 3 && cyc <= 2 + ln) chk("full_rate", m_valid, 1);
      if (done) begin
        seen = 1;
        chk("busy_at_done", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
      end
    end
    if (!seen) chk("xfer_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      exp_zl  = 0;
      start   = 1'b0;
      m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int k, idx;
    bit seen6;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    start6 = 1'b0; base6 = '0; len6 = '0; ready6 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ena", ram_ena, 0);
    chk("rst_wea", ram_wea, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    xfer(2, 4, 0, 0); idle(2);
    xfer(6, 5, 0, 0); idle(2);
    xfer(0, 8, 1, 0); idle(2);
    xfer(3, 8, 1, 0); idle(2);
    xfer(1, 8, 0, 0); idle(2);
    xfer(5, 0, 0, 0); idle(2);
    xfer(4, 6, 1, 1);
    xfer(7, 3, 0, 0); idle(2);

    // Mid-transfer reset with one word buffered and one read in flight.
    m_ready = 1'b0;
    do_start(3, 8);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_valid", m_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ena", ram_ena, 0);
    chk("mid_rst_addr", ram_addr, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_last", m_last, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    xfer(0, 3, 0, 0); idle(2);

    for (int i = 0; i < 8; i++) begin
      xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
           int'($urandom_range(0, 1)), 0);
      idle(1);
    end

    // DEPTH=6 wrap: base 4, len 4 -> addresses 4,5,0,1.
    start6 = 1'b1; base6 = 3'd4; len6 = 4'd4;
    k = 0; idx = 0; seen6 = 0;
    for (int cyc = 1; cyc < 40 && !seen6; cyc++) begin
      @(posedge clk); #1;
      start6 = 1'b0;
      @(negedge clk);
      if (ena6) begin
        chk("d6_addr", addr6, (4 + idx) % 6);
        idx++;
      end
      if (valid6 && ready6) begin
        chk("d6_data", data6, 8'h10 + (4 + k) % 6);
        chk("d6_last", last6, k == 3);
        k++;
      end
      if (done6) seen6 = 1;
    end
    chk("d6_done_seen", seen6, 1);
    chk("d6_reads", idx, 4);
    chk("d6_words", k, 4);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
